mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the four requester ports and the shared memory port of mem_port_arbiter.
// The slave modport is the arbiter side; the master modport is the requesters and memory side.
interface mem_port_arbiter_if;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [31:0] addr0, addr1, addr2, addr3;
  logic [31:0] wdata0, wdata1, wdata2, wdata3;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  sel;
  logic [3:0]  gnt;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] rdata;
  logic [3:0]  done;
  logic [3:0]  err;

  modport slave (
    input  req, we, addr0, addr1, addr2, addr3,
    input  wdata0, wdata1, wdata2, wdata3, mem_ready, mem_rdata,
    output sel, gnt, mem_valid, mem_we, mem_addr, mem_wdata, rdata, done, err
  );

  modport master (
    output req, we, addr0, addr1, addr2, addr3,
    output wdata0, wdata1, wdata2, wdata3, mem_ready, mem_rdata,
    input  sel, gnt, mem_valid, mem_we, mem_addr, mem_wdata, rdata, done, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin 4:1 memory port arbiter with wait timeout; grant one cycle after req.
// Backpressure: access is held until mem_ready or TIMEOUT wait cycles, then one TURN cycle.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [1:0]  ptr;
  logic [1:0]  sel_q;
  logic        mem_we_q;
  logic [7:0]  wait_cnt;
  logic [31:0] rdata_q;
  logic [3:0]  done_q, err_q;
  logic [1:0]  winner, idx;
  logic        found;
  logic        complete, expire;

  // Search ptr+1, ptr+2, ptr+3, ptr; the first requester found wins.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Completion beats timeout when both land on the same cycle.
  assign complete = (state == BUSY) && bus.mem_ready;
  assign expire   = (state == BUSY) && !bus.mem_ready && (wait_cnt >= WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = BUSY;
      BUSY:    if (complete || expire) state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 2'd3;
      sel_q    <= 2'd0;
      mem_we_q <= 1'b0;
      wait_cnt <= 8'd0;
      rdata_q  <= 32'd0;
      done_q   <= 4'd0;
      err_q    <= 4'd0;
    end else begin
      done_q <= complete ? (4'b0001 << sel_q) : 4'd0;
      err_q  <= expire   ? (4'b0001 << sel_q) : 4'd0;
      if (state == IDLE && found) begin
        sel_q    <= winner;
        mem_we_q <= bus.we[winner];
        wait_cnt <= 8'd0;
      end else if (state == BUSY && !bus.mem_ready && wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (complete) rdata_q <= bus.mem_rdata;
      if (complete || expire) begin
        ptr      <= sel_q;
        mem_we_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.mem_addr  = bus.addr0;
    bus.mem_wdata = bus.wdata0;
    case (sel_q)
      2'd1: begin bus.mem_addr = bus.addr1; bus.mem_wdata = bus.wdata1; end
      2'd2: begin bus.mem_addr = bus.addr2; bus.mem_wdata = bus.wdata2; end
      2'd3: begin bus.mem_addr = bus.addr3; bus.mem_wdata = bus.wdata3; end
      default: begin bus.mem_addr = bus.addr0; bus.mem_wdata = bus.wdata0; end
    endcase
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = (state == BUSY) ? (4'b0001 << sel_q) : 4'd0;
  assign bus.mem_valid = (state == BUSY);
  assign bus.mem_we    = mem_we_q;
  assign bus.rdata     = rdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized transaction-level check of mem_port_arbiter against a round-robin reference model.
// Each access is modelled as: winner by rotation, hold until ready or TIMEOUT waits, one TURN cycle.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          ptr_m = 3;
  logic [31:0] rdata_m = 32'd0;
  logic [31:0] addr_v [4];
  logic [31:0] wdata_v[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ports();
    for (int i = 0; i < 4; i++) begin
      addr_v[i]  = $urandom();
      wdata_v[i] = $urandom();
    end
  endtask

  task automatic drive_ports();
    bus.addr0  = addr_v[0];  bus.addr1  = addr_v[1];
    bus.addr2  = addr_v[2];  bus.addr3  = addr_v[3];
    bus.wdata0 = wdata_v[0]; bus.wdata1 = wdata_v[1];
    bus.wdata2 = wdata_v[2]; bus.wdata3 = wdata_v[3];
  endtask

  // One access from IDLE; ready_at = BUSY cycle carrying mem_ready (0 or >TO means none).
  task automatic do_txn(input logic [3:0] reqv, input logic [3:0] wev, input int ready_at,
                        input logic [31:0] rd, input bit keep_req);
    int w;
    int last;
    bit ok;
    w    = rr_pick(ptr_m, reqv);
    ok   = (ready_at >= 1) && (ready_at <= TO);
    last = ok ? ready_at : TO;
    bus.req = reqv;
    bus.we  = wev;
    drive_ports();
    bus.mem_ready = 1'b0;
    step();
    for (int k = 1; k <= last; k++) begin
      check("busy_valid", 32'(bus.mem_valid), 32'd1);
      check("busy_gnt",   32'(bus.gnt), 32'(4'b0001 << w));
      check("busy_sel",   32'(bus.sel), 32'(w));
      check("busy_we",    32'(bus.mem_we), 32'(wev[w]));
      check("busy_addr",  bus.mem_addr, addr_v[w]);
      check("busy_wdata", bus.mem_wdata, wdata_v[w]);
      if ((k == 1 && !keep_req) || k == last) bus.req = 4'd0;
      bus.mem_ready = (k == ready_at);
      bus.mem_rdata = (k == ready_at) ? rd : $urandom();
      step();
    end
    if (ok) rdata_m = rd;
    check("turn_done",  32'(bus.done), ok ? 32'(4'b0001 << w) : 32'd0);
    check("turn_err",   32'(bus.err),  ok ? 32'd0 : 32'(4'b0001 << w));
    check("turn_rdata", bus.rdata, rdata_m);
    check("turn_valid", 32'(bus.mem_valid), 32'd0);
    check("turn_gnt",   32'(bus.gnt), 32'd0);
    ptr_m = w;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom();
    step();
    check("idle_valid", 32'(bus.mem_valid), 32'd0);
    check("idle_pulse", 32'({bus.done, bus.err}), 32'd0);
    check("idle_rdata", bus.rdata, rdata_m);
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    int n;
    int lastc;
    int expw;
    rst_n = 1'b0;
    bus.req = 4'd0; bus.we = 4'd0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    randomize_ports();
    drive_ports();
    #1;
    check("rst_sel",   32'(bus.sel), 32'd0);
    check("rst_gnt",   32'(bus.gnt), 32'd0);
    check("rst_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_we",    32'(bus.mem_we), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_pulse", 32'({bus.done, bus.err}), 32'd0);
    step(); step();
    rst_n = 1'b1;

    // Nothing requested: stays idle even with stray mem_ready.
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      step();
      check("noreq_valid", 32'(bus.mem_valid), 32'd0);
      check("noreq_gnt",   32'(bus.gnt), 32'd0);
      check("noreq_pulse", 32'({bus.done, bus.err}), 32'd0);
    end
    bus.mem_ready = 1'b0;

    randomize_ports();
    addr_v[0] = 32'h100;
    do_txn(4'b0001, 4'b0000, 3, 32'hDEADBEEF, 1'b0);

    randomize_ports();
    wdata_v[1] = 32'h12345678;
    do_txn(4'b0010, 4'b0010, 2, 32'h0BADF00D, 1'b0);

    randomize_ports();
    do_txn(4'b0100, 4'b0100, 0, 32'h0, 1'b1);
    randomize_ports();
    do_txn(4'b1111, 4'b0000, 1, 32'hCAFE0001, 1'b0);

    randomize_ports();
    do_txn(4'b0011, 4'b0001, TO, 32'h7E570000, 1'b1);

    // Reset while BUSY.
    randomize_ports();
    bus.req = 4'b0110;
    drive_ports();
    step();
    check("pre_rst_valid", 32'(bus.mem_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_gnt",   32'(bus.gnt), 32'd0);
    check("mid_rst_valid", 32'(bus.mem_valid), 32'd0);
    check("mid_rst_pulse", 32'({bus.done, bus.err}), 32'd0);
    check("mid_rst_rdata", bus.rdata, 32'd0);
    bus.req = 4'd0;
    step();
    rst_n = 1'b1;
    ptr_m   = 3;
    rdata_m = 32'd0;
    randomize_ports();
    do_txn(4'b1000, 4'b1000, 1, 32'h33333333, 1'b0);

    // Fairness: all requesting, memory always ready.
    ptr_m = 3;
    expw  = ptr_m;
    n     = 0;
    lastc = -1;
    bus.req = 4'b1111;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hA5A50000;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      step();
      if (bus.gnt != 4'd0) begin
        expw = (expw + 1) % 4;
        check("fair_gnt", 32'(bus.gnt), 32'(4'b0001 << expw));
        if (n > 0) check("fair_gap", 32'(cyc - lastc), 32'd3);
        lastc = cyc;
        n++;
        if (n == 5) bus.req = 4'd0;
      end
    end
    check("fair_count", 32'(n), 32'd5);
    step(); step();
    bus.mem_ready = 1'b0;
    ptr_m   = expw;
    rdata_m = 32'hA5A50000;
    check("fair_rdata", bus.rdata, rdata_m);

    for (int t = 0; t < 40; t++) begin
      randomize_ports();
      do_txn(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
             $urandom_range(0, TO), $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
